// File: rtl/trading_pkg.sv
// Shared constants for the UDP order path: opcodes, frame byte offsets,
// order-word field positions and the parser state encoding.
package trading_pkg;

    localparam logic [23:0] OPC_ORDER = 24'h102030;
    localparam logic [23:0] OPC_DUMP  = 24'hF0E0D0;

    localparam logic [5:0] ETYPE_OFS       = 6'd12;
    localparam logic [5:0] PROTO_OFS       = 6'd23;
    localparam logic [5:0] IP_OFS          = 6'd30;
    localparam logic [5:0] PORT_OFS        = 6'd34;
    localparam logic [5:0] OPC_OFS         = 6'd42;
    localparam logic [5:0] PAY_OFS         = 6'd45;
    localparam logic [5:0] FRAME_LEN_ORDER = 6'd49;
    localparam logic [5:0] FRAME_LEN_DUMP  = 6'd45;

    localparam int PRICE_MSB = 31;
    localparam int BUY_BIT   = 15;
    localparam int BOT_BIT   = 14;
    localparam int QTY_MSB   = 13;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_OPC,
        ST_PAY,
        ST_DRAIN
    } parser_state_e;

    function automatic logic [31:0] pack_order(input logic [15:0] price, input logic is_buy,
                                                input logic bot, input logic [QTY_MSB:0] qty);
        logic [31:0] w;
        w                          = '0;
        w[PRICE_MSB -: 16]         = price;
        w[BUY_BIT]                 = is_buy;
        w[BOT_BIT]                 = bot;
        w[QTY_MSB:0]               = qty;
        return w;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Statistics counter that increments on a one-cycle strobe and sticks at all-ones.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_count
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_inc && (r_count != '1)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/udp_order_extractor.sv
// Parses UDP frames from the MAC RX stream, filters on IP/port, and turns
// market-data frames into order words and dump frames into dump requests.
module udp_order_extractor #(
    parameter logic [31:0] FILTER_IP   = 32'hC0A80132,
    parameter logic [15:0] FILTER_PORT = 16'hD903,
    parameter logic [23:0] OPC_ORDER   = trading_pkg::OPC_ORDER,
    parameter logic [23:0] OPC_DUMP    = trading_pkg::OPC_DUMP,
    parameter int          CNT_W       = 16
) (
    input  logic             clk_udp,
    input  logic             rst_udp,
    input  logic [7:0]       rx_axis_tdata,
    input  logic             rx_axis_tvalid,
    input  logic             rx_axis_tlast,
    output logic [31:0]      order_data,
    output logic             order_valid,
    input  logic             order_full,
    output logic             dump_req,
    output logic [CNT_W-1:0] pkt_ok_count,
    output logic [CNT_W-1:0] pkt_drop_count,
    output logic [CNT_W-1:0] overflow_count
);

    import trading_pkg::*;

    localparam logic [5:0] ORDER_LAST_IDX = FRAME_LEN_ORDER - 6'd1;
    localparam logic [5:0] DUMP_LAST_IDX  = FRAME_LEN_DUMP - 6'd1;

    parser_state_e r_state;
    logic [5:0]    r_idx;
    logic          r_hdr_ok;
    logic [23:0]   r_opc;
    logic [31:0]   r_pay;
    logic [31:0]   r_order_data;
    logic          r_order_valid;
    logic          r_dump_req;

    logic          w_hdr_mismatch;
    logic          w_hdr_ok_n;
    logic [23:0]   w_opc_n;
    logic [31:0]   w_pay_n;
    logic [5:0]    w_idx_inc;
    parser_state_e w_state_n;
    logic          w_end_beat;
    logic          w_is_order;
    logic          w_is_dump;
    logic          w_order_fire;
    logic          w_ok_inc;
    logic          w_drop_inc;
    logic          w_ovf_inc;

    always_comb begin
        w_hdr_mismatch = 1'b0;
        case (r_idx)
            ETYPE_OFS:          w_hdr_mismatch = (rx_axis_tdata != 8'h08);
            ETYPE_OFS + 6'd1:   w_hdr_mismatch = (rx_axis_tdata != 8'h00);
            PROTO_OFS:          w_hdr_mismatch = (rx_axis_tdata != 8'h11);
            IP_OFS:             w_hdr_mismatch = (rx_axis_tdata != FILTER_IP[31:24]);
            IP_OFS + 6'd1:      w_hdr_mismatch = (rx_axis_tdata != FILTER_IP[23:16]);
            IP_OFS + 6'd2:      w_hdr_mismatch = (rx_axis_tdata != FILTER_IP[15:8]);
            IP_OFS + 6'd3:      w_hdr_mismatch = (rx_axis_tdata != FILTER_IP[7:0]);
            PORT_OFS:           w_hdr_mismatch = (rx_axis_tdata != FILTER_PORT[15:8]);
            PORT_OFS + 6'd1:    w_hdr_mismatch = (rx_axis_tdata != FILTER_PORT[7:0]);
            default:            w_hdr_mismatch = 1'b0;
        endcase
    end

    // The first beat of a frame re-arms the sticky header flag.
    assign w_hdr_ok_n = ((r_state == ST_IDLE) ? 1'b1 : r_hdr_ok) & ~w_hdr_mismatch;
    assign w_opc_n    = (r_state == ST_OPC) ? {r_opc[15:0], rx_axis_tdata} : r_opc;
    assign w_pay_n    = (r_state == ST_PAY) ? {r_pay[23:0], rx_axis_tdata} : r_pay;
    assign w_idx_inc  = (r_idx == 6'd63) ? r_idx : r_idx + 6'd1;

    always_comb begin
        if (w_idx_inc < OPC_OFS)              w_state_n = ST_HDR;
        else if (w_idx_inc < PAY_OFS)         w_state_n = ST_OPC;
        else if (w_idx_inc < FRAME_LEN_ORDER) w_state_n = ST_PAY;
        else                                  w_state_n = ST_DRAIN;
    end

    // Classification uses the values this last beat would shift in, so the
    // decision lands on the tlast beat and the strobe one cycle later.
    assign w_end_beat   = rx_axis_tvalid & rx_axis_tlast;
    assign w_is_order   = w_end_beat & w_hdr_ok_n & (w_opc_n == OPC_ORDER)
                        & (r_idx == ORDER_LAST_IDX) & (w_pay_n[QTY_MSB:0] != '0);
    assign w_is_dump    = w_end_beat & w_hdr_ok_n & (w_opc_n == OPC_DUMP)
                        & (r_idx == DUMP_LAST_IDX);
    assign w_order_fire = w_is_order & ~order_full;
    assign w_ok_inc     = w_order_fire | w_is_dump;
    assign w_ovf_inc    = w_is_order & order_full;
    assign w_drop_inc   = w_end_beat & ~w_is_order & ~w_is_dump;

    always_ff @(posedge clk_udp) begin
        if (rst_udp) begin
            r_state       <= ST_IDLE;
            r_idx         <= '0;
            r_hdr_ok      <= 1'b0;
            r_opc         <= '0;
            r_pay         <= '0;
            r_order_data  <= '0;
            r_order_valid <= 1'b0;
            r_dump_req    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling the pre-edge values.
            r_order_valid <= w_order_fire;
            r_dump_req    <= w_is_dump;
            if (w_order_fire) begin
                r_order_data <= w_pay_n;
            end
            if (rx_axis_tvalid) begin
                if (rx_axis_tlast) begin
                    r_state  <= ST_IDLE;
                    r_idx    <= '0;
                    r_hdr_ok <= 1'b0;
                    r_opc    <= '0;
                    r_pay    <= '0;
                end else begin
                    r_state  <= w_state_n;
                    r_idx    <= w_idx_inc;
                    r_hdr_ok <= w_hdr_ok_n;
                    r_opc    <= w_opc_n;
                    r_pay    <= w_pay_n;
                end
            end
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_ok_cnt (
        .i_clk   (clk_udp),
        .i_rst   (rst_udp),
        .i_inc   (w_ok_inc),
        .o_count (pkt_ok_count)
    );

    sat_counter #(.CNT_W(CNT_W)) u_drop_cnt (
        .i_clk   (clk_udp),
        .i_rst   (rst_udp),
        .i_inc   (w_drop_inc),
        .o_count (pkt_drop_count)
    );

    sat_counter #(.CNT_W(CNT_W)) u_ovf_cnt (
        .i_clk   (clk_udp),
        .i_rst   (rst_udp),
        .i_inc   (w_ovf_inc),
        .o_count (overflow_count)
    );

    assign order_data  = r_order_data;
    assign order_valid = r_order_valid;
    assign dump_req    = r_dump_req;

endmodule

// File: tb/tb_udp_order_extractor.sv
// Directed bench for udp_order_extractor: valid orders/dumps, filtering,
// overflow, framing errors, back-to-back frames and mid-frame reset.
module tb_udp_order_extractor;

    logic        clk_udp = 1'b0;
    logic        rst_udp = 1'b1;
    logic [7:0]  rx_axis_tdata = '0;
    logic        rx_axis_tvalid = 1'b0;
    logic        rx_axis_tlast = 1'b0;
    logic        order_full = 1'b0;
    logic [31:0] order_data;
    logic        order_valid;
    logic        dump_req;
    logic [15:0] pkt_ok_count;
    logic [15:0] pkt_drop_count;
    logic [15:0] overflow_count;

    int n_checks = 0;
    int n_errors = 0;
    int n_ord_seen = 0;
    int n_dump_seen = 0;
    logic [31:0] order_q[$];
    logic [7:0]  frame [64];

    udp_order_extractor dut (
        .clk_udp        (clk_udp),
        .rst_udp        (rst_udp),
        .rx_axis_tdata  (rx_axis_tdata),
        .rx_axis_tvalid (rx_axis_tvalid),
        .rx_axis_tlast  (rx_axis_tlast),
        .order_data     (order_data),
        .order_valid    (order_valid),
        .order_full     (order_full),
        .dump_req       (dump_req),
        .pkt_ok_count   (pkt_ok_count),
        .pkt_drop_count (pkt_drop_count),
        .overflow_count (overflow_count)
    );

    always #4 clk_udp = ~clk_udp;

    always @(negedge clk_udp) begin
        if (order_valid) begin
            n_ord_seen++;
            order_q.push_back(order_data);
        end
        if (dump_req) n_dump_seen++;
        if (order_valid || dump_req) begin
            n_checks++;
            if (order_valid && dump_req) begin
                n_errors++;
                $display("FAIL both_strobes: got order_valid=1 dump_req=1 want at most one");
            end
        end
    end

    task automatic make_frame(input logic [15:0] price, input logic buy, input logic [13:0] qty,
                              input logic [23:0] opc, input logic [31:0] ip, input logic [15:0] port);
        logic [31:0] w;
        w = {price, buy, 1'b0, qty};
        for (int i = 0; i < 64; i++) frame[i] = 8'(8'hA0 + i);
        frame[12] = 8'h08; frame[13] = 8'h00; frame[23] = 8'h11;
        frame[30] = ip[31:24]; frame[31] = ip[23:16]; frame[32] = ip[15:8]; frame[33] = ip[7:0];
        frame[34] = port[15:8]; frame[35] = port[7:0];
        frame[42] = opc[23:16]; frame[43] = opc[15:8]; frame[44] = opc[7:0];
        frame[45] = w[31:24]; frame[46] = w[23:16]; frame[47] = w[15:8]; frame[48] = w[7:0];
    endtask

    task automatic send_beat(input logic [7:0] d, input logic last);
        rx_axis_tvalid = 1'b1; rx_axis_tdata = d; rx_axis_tlast = last;
        @(posedge clk_udp); #1;
    endtask

    task automatic send_frame(input int len, input int max_gap);
        for (int i = 0; i < len; i++) begin
            int gaps;
            gaps = (max_gap > 0 && i > 0) ? int'($urandom_range(max_gap, 0)) : 0;
            repeat (gaps) begin
                rx_axis_tvalid = 1'b0; rx_axis_tlast = 1'b0;
                @(posedge clk_udp); #1;
            end
            send_beat(frame[i], i == len - 1);
        end
    endtask

    task automatic idle(input int n);
        rx_axis_tvalid = 1'b0; rx_axis_tlast = 1'b0;
        repeat (n) begin @(posedge clk_udp); #1; end
    endtask

    task automatic test_reset;
        rst_udp = 1'b1;
        repeat (2) begin @(posedge clk_udp); #1; end
        n_checks++; if (order_valid !== 1'b0) begin n_errors++; $display("FAIL rst_order_valid: got %b want 0", order_valid); end
        n_checks++; if (dump_req !== 1'b0) begin n_errors++; $display("FAIL rst_dump_req: got %b want 0", dump_req); end
        n_checks++; if (order_data !== 32'h0) begin n_errors++; $display("FAIL rst_order_data: got %h want 0", order_data); end
        n_checks++; if (pkt_ok_count !== 16'd0) begin n_errors++; $display("FAIL rst_ok: got %0d want 0", pkt_ok_count); end
        n_checks++; if (pkt_drop_count !== 16'd0) begin n_errors++; $display("FAIL rst_drop: got %0d want 0", pkt_drop_count); end
        n_checks++; if (overflow_count !== 16'd0) begin n_errors++; $display("FAIL rst_ovf: got %0d want 0", overflow_count); end
        rst_udp = 1'b0;
        idle(2);
    endtask

    task automatic test_order;
        make_frame(16'h0064, 1'b0, 14'd10, 24'h102030, 32'hC0A80132, 16'hD903);
        send_frame(49, 0);
        rx_axis_tvalid = 1'b0; rx_axis_tlast = 1'b0;
        n_checks++; if (order_valid !== 1'b1) begin n_errors++; $display("FAIL order_pulse: got %b want 1", order_valid); end
        n_checks++; if (order_data !== 32'h0064000A) begin n_errors++; $display("FAIL order_data: got %h want 0064000a", order_data); end
        idle(1);
        n_checks++; if (order_valid !== 1'b0) begin n_errors++; $display("FAIL order_one_cycle: got %b want 0", order_valid); end
        idle(2);
        n_checks++; if (n_ord_seen !== 1) begin n_errors++; $display("FAIL order_count: got %0d want 1", n_ord_seen); end
        n_checks++; if (pkt_ok_count !== 16'd1) begin n_errors++; $display("FAIL order_ok: got %0d want 1", pkt_ok_count); end
        n_checks++; if (pkt_drop_count !== 16'd0) begin n_errors++; $display("FAIL order_drop: got %0d want 0", pkt_drop_count); end
    endtask

    task automatic test_dump;
        make_frame(16'h0000, 1'b0, 14'd0, 24'hF0E0D0, 32'hC0A80132, 16'hD903);
        send_frame(45, 0);
        rx_axis_tvalid = 1'b0; rx_axis_tlast = 1'b0;
        n_checks++; if (dump_req !== 1'b1) begin n_errors++; $display("FAIL dump_pulse: got %b want 1", dump_req); end
        idle(3);
        n_checks++; if (n_dump_seen !== 1) begin n_errors++; $display("FAIL dump_count: got %0d want 1", n_dump_seen); end
        n_checks++; if (n_ord_seen !== 1) begin n_errors++; $display("FAIL dump_no_order: got %0d want 1", n_ord_seen); end
        n_checks++; if (pkt_ok_count !== 16'd2) begin n_errors++; $display("FAIL dump_ok: got %0d want 2", pkt_ok_count); end
    endtask

    task automatic test_filter;
        make_frame(16'h0064, 1'b0, 14'd10, 24'h102030, 32'hC0A80133, 16'hD903);
        send_frame(49, 0);
        idle(3);
        n_checks++; if (pkt_drop_count !== 16'd1) begin n_errors++; $display("FAIL filter_ip_drop: got %0d want 1", pkt_drop_count); end
        make_frame(16'h0064, 1'b0, 14'd10, 24'h102030, 32'hC0A80132, 16'hD904);
        send_frame(49, 0);
        rx_axis_tvalid = 1'b0; rx_axis_tlast = 1'b0;
        n_checks++; if (order_valid !== 1'b0) begin n_errors++; $display("FAIL filter_port_strobe: got %b want 0", order_valid); end
        idle(3);
        n_checks++; if (pkt_drop_count !== 16'd2) begin n_errors++; $display("FAIL filter_port_drop: got %0d want 2", pkt_drop_count); end
        n_checks++; if (n_ord_seen !== 1) begin n_errors++; $display("FAIL filter_orders: got %0d want 1", n_ord_seen); end
        n_checks++; if (pkt_ok_count !== 16'd2) begin n_errors++; $display("FAIL filter_ok: got %0d want 2", pkt_ok_count); end
    endtask

    task automatic test_overflow;
        make_frame(16'h0064, 1'b0, 14'd10, 24'h102030, 32'hC0A80132, 16'hD903);
        order_full = 1'b1;
        send_frame(49, 0);
        rx_axis_tvalid = 1'b0; rx_axis_tlast = 1'b0;
        n_checks++; if (order_valid !== 1'b0) begin n_errors++; $display("FAIL ovf_strobe: got %b want 0", order_valid); end
        idle(3);
        order_full = 1'b0;
        n_checks++; if (overflow_count !== 16'd1) begin n_errors++; $display("FAIL ovf_count: got %0d want 1", overflow_count); end
        n_checks++; if (pkt_drop_count !== 16'd2) begin n_errors++; $display("FAIL ovf_drop: got %0d want 2", pkt_drop_count); end
        n_checks++; if (pkt_ok_count !== 16'd2) begin n_errors++; $display("FAIL ovf_ok: got %0d want 2", pkt_ok_count); end
        n_checks++; if (n_ord_seen !== 1) begin n_errors++; $display("FAIL ovf_orders: got %0d want 1", n_ord_seen); end
    endtask

    task automatic test_framing;
        make_frame(16'h0064, 1'b0, 14'd10, 24'h102030, 32'hC0A80132, 16'hD903);
        send_frame(48, 0); idle(2);
        send_frame(50, 0); idle(2);
        make_frame(16'h0064, 1'b0, 14'd0, 24'h102030, 32'hC0A80132, 16'hD903);
        send_frame(49, 0); idle(2);
        make_frame(16'h0064, 1'b0, 14'd10, 24'hF0E0D0, 32'hC0A80132, 16'hD903);
        send_frame(49, 0); idle(3);
        n_checks++; if (pkt_drop_count !== 16'd6) begin n_errors++; $display("FAIL framing_drop: got %0d want 6", pkt_drop_count); end
        n_checks++; if (n_ord_seen !== 1) begin n_errors++; $display("FAIL framing_orders: got %0d want 1", n_ord_seen); end
        n_checks++; if (n_dump_seen !== 1) begin n_errors++; $display("FAIL framing_dumps: got %0d want 1", n_dump_seen); end
        n_checks++; if (pkt_ok_count !== 16'd2) begin n_errors++; $display("FAIL framing_ok: got %0d want 2", pkt_ok_count); end
    endtask

    task automatic test_back_to_back;
        make_frame(16'h1234, 1'b1, 14'd5, 24'h102030, 32'hC0A80132, 16'hD903);
        send_frame(49, 2);
        make_frame(16'h00FF, 1'b0, 14'h3FFF, 24'h102030, 32'hC0A80132, 16'hD903);
        send_frame(49, 2);
        make_frame(16'hABCD, 1'b1, 14'd1, 24'h102030, 32'hC0A80132, 16'hD903);
        send_frame(49, 2);
        idle(3);
        n_checks++; if (n_ord_seen !== 4) begin n_errors++; $display("FAIL b2b_count: got %0d want 4", n_ord_seen); end
        if (order_q.size() >= 4) begin
            n_checks++; if (order_q[1] !== 32'h12348005) begin n_errors++; $display("FAIL b2b_word0: got %h want 12348005", order_q[1]); end
            n_checks++; if (order_q[2] !== 32'h00FF3FFF) begin n_errors++; $display("FAIL b2b_word1: got %h want 00ff3fff", order_q[2]); end
            n_checks++; if (order_q[3] !== 32'hABCD8001) begin n_errors++; $display("FAIL b2b_word2: got %h want abcd8001", order_q[3]); end
        end
        n_checks++; if (pkt_ok_count !== 16'd5) begin n_errors++; $display("FAIL b2b_ok: got %0d want 5", pkt_ok_count); end
        n_checks++; if (order_data !== 32'hABCD8001) begin n_errors++; $display("FAIL b2b_hold: got %h want abcd8001", order_data); end
    endtask

    task automatic test_mid_reset;
        make_frame(16'h0200, 1'b1, 14'h20, 24'h102030, 32'hC0A80132, 16'hD903);
        for (int i = 0; i < 20; i++) send_beat(frame[i], 1'b0);
        rst_udp = 1'b1;
        send_beat(frame[20], 1'b0);
        rst_udp = 1'b0;
        n_checks++; if (order_data !== 32'h0) begin n_errors++; $display("FAIL mrst_data: got %h want 0", order_data); end
        n_checks++; if (pkt_ok_count !== 16'd0) begin n_errors++; $display("FAIL mrst_ok: got %0d want 0", pkt_ok_count); end
        n_checks++; if (pkt_drop_count !== 16'd0) begin n_errors++; $display("FAIL mrst_drop: got %0d want 0", pkt_drop_count); end
        n_checks++; if (overflow_count !== 16'd0) begin n_errors++; $display("FAIL mrst_ovf: got %0d want 0", overflow_count); end
        for (int i = 21; i < 49; i++) send_beat(frame[i], i == 48);
        idle(3);
        n_checks++; if (pkt_drop_count !== 16'd1) begin n_errors++; $display("FAIL mrst_tail_drop: got %0d want 1", pkt_drop_count); end
        n_checks++; if (n_ord_seen !== 4) begin n_errors++; $display("FAIL mrst_tail_orders: got %0d want 4", n_ord_seen); end
        send_frame(49, 0);
        idle(3);
        n_checks++; if (pkt_ok_count !== 16'd1) begin n_errors++; $display("FAIL mrst_next_ok: got %0d want 1", pkt_ok_count); end
        n_checks++; if (order_data !== 32'h02008020) begin n_errors++; $display("FAIL mrst_next_data: got %h want 02008020", order_data); end
        n_checks++; if (n_ord_seen !== 5) begin n_errors++; $display("FAIL mrst_next_orders: got %0d want 5", n_ord_seen); end
    endtask

    initial begin
        test_reset();
        test_order();
        test_dump();
        test_filter();
        test_overflow();
        test_framing();
        test_back_to_back();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
